// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic feeder: default geometry, FSM states and the
// flush-length helper.
package systolic_pkg;

    localparam int DEF_LANES    = 8;
    localparam int DEF_DEPTH    = 8;
    localparam int FLUSH_CYCLES = DEF_LANES - 1;

    typedef enum logic [1:0] {
        LOAD,
        STREAM,
        FLUSH,
        DONE
    } feeder_state_e;

    // The last lane lags lane 0 by lanes-1 cycles, so the skew needs that many zero cycles to drain.
    function automatic int flush_cycles(input int lanes);
        return lanes - 1;
    endfunction

endpackage

// File: rtl/systolic_feeder_skew_delay_line.sv
// Fixed-length shift register for one lane of the skew stage. It carries a data bit and
// a window-valid bit in parallel, and the final stage is the output register.
module skew_delay_line #(
    parameter int DELAY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic vin,
    output logic dout,
    output logic vout
);

    logic [DELAY-1:0] dat_q, dat_d;
    logic [DELAY-1:0] vld_q, vld_d;

    always_comb begin
        dat_d    = '0;
        vld_d    = '0;
        dat_d[0] = din;
        vld_d[0] = vin;
        for (int i = 1; i < DELAY; i++) begin
            dat_d[i] = dat_q[i-1];
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dat_q <= '0;
            vld_q <= '0;
        end else begin
            dat_q <= dat_d;
            vld_q <= vld_d;
        end
    end

    assign dout = dat_q[DELAY-1];
    assign vout = vld_q[DELAY-1];

endmodule

// File: rtl/systolic_feeder.sv
// Buffers a tile of row words and replays it diagonally skewed into the systolic array.
//   state  | meaning
//   LOAD   | accept rows until the tile is full, or until go arrives with at least one row
//   STREAM | present rows 0..DEPTH-1 to the skew stage, with zeros for rows that were never loaded
//   FLUSH  | present zeros while the skewed tail drains (LANES-1 cycles)
//   DONE   | last skewed bit is on array_out, so pulse done and clear the counters
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LANES-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             go,
    output logic [LANES-1:0] array_out,
    output logic [LANES-1:0] lane_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(LANES + 1);
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_ROW   = CW'(DEPTH - 1);
    localparam logic [TW-1:0] FLUSH_LOAD = TW'(flush_cycles(LANES) - 1);

    feeder_state_e    state_q, state_d;
    logic [CW-1:0]    wr_cnt_q, wr_cnt_d, wr_next;
    logic [CW-1:0]    rd_cnt_q, rd_cnt_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [LANES-1:0] row_q [DEPTH];
    logic [LANES-1:0] row_d [DEPTH];
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;
    logic [LANES-1:0] feed_bits;
    logic             feed_valid;

    always_comb begin
        accept     = (state_q == LOAD) && in_valid && in_ready_q;
        wr_next    = wr_cnt_q + CW'(accept);
        state_d    = state_q;
        wr_cnt_d   = wr_next;
        rd_cnt_d   = rd_cnt_q;
        tmr_d      = tmr_q;
        row_d      = row_q;
        feed_bits  = '0;
        feed_valid = 1'b0;
        if (accept) begin
            row_d[wr_cnt_q[AW-1:0]] = in_data;
        end
        unique case (state_q)
            LOAD: begin
                // A write landing in the same cycle as go is part of the tile.
                if ((wr_next == DEPTH_C) || (go && (wr_next != '0))) begin
                    state_d  = STREAM;
                    rd_cnt_d = '0;
                end
            end
            STREAM: begin
                feed_valid = 1'b1;
                feed_bits  = (rd_cnt_q < wr_cnt_q) ? row_q[rd_cnt_q[AW-1:0]] : '0;
                rd_cnt_d   = rd_cnt_q + CW'(1);
                if (rd_cnt_q == LAST_ROW) begin
                    state_d = FLUSH;
                    tmr_d   = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (tmr_q == '0) begin
                    state_d = DONE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            DONE: begin
                state_d  = LOAD;
                wr_cnt_d = '0;
                rd_cnt_d = '0;
            end
            default: state_d = LOAD;
        endcase
        in_ready_d = (state_d == LOAD) && (wr_cnt_d < DEPTH_C);
        busy_d     = (state_d != LOAD);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= LOAD;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            tmr_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                row_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            tmr_q      <= tmr_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            row_q      <= row_d;
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        skew_delay_line #(
            .DELAY(j + 1)
        ) u_dly (
            .clk  (clk),
            .reset(reset),
            .din  (feed_bits[j]),
            .vin  (feed_valid),
            .dout (array_out[j]),
            .vout (lane_valid[j])
        );
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
